// File: rtl/stripe_decoder_if.sv
// Sensor inputs and decoded outputs of the stripe decoder, grouped as one bus.
interface stripe_decoder_if;
    logic        reflectF;
    logic        reflectM;
    logic        reflectR;
    logic        clear;
    logic [15:0] stripe_count;
    logic [63:0] position;
    logic [31:0] period;
    logic        period_valid;
    logic        stripe_pulse;
    logic        seq_error;

    // Driver side: owns the sensors and clear, observes the decoded state
    modport master (
        output reflectF, reflectM, reflectR, clear,
        input  stripe_count, position, period, period_valid, stripe_pulse, seq_error
    );

    // Decoder side
    modport slave (
        input  reflectF, reflectM, reflectR, clear,
        output stripe_count, position, period, period_valid, stripe_pulse, seq_error
    );
endinterface

// File: rtl/stripe_decoder.sv
// Stripe decoder: synchronises and debounces the front/middle/rear reflective
// sensors, counts front-stripe edges, reconstructs position and stripe period,
// and flags sensor events that arrive out of F -> M -> R order.
module stripe_decoder #(
    parameter logic [63:0] STRIPE_PITCH    = 64'd30480000000,
    parameter logic [63:0] FIRST_OFFSET    = 64'd15240000000,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    stripe_decoder_if.slave bus
);
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSeenF, StSeenM} state_e;

    // Sensor vectors are ordered {R, M, F}
    logic [2:0]      raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      filt_q, filt_d;
    logic [2:0]      prev_q;
    logic [2:0]      rise;
    logic [CntW-1:0] deb_q [3];
    logic [CntW-1:0] deb_d [3];

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [63:0] position_q, position_d;
    logic [31:0] period_q, period_d;
    logic [31:0] pcnt_q, pcnt_d, pcnt_inc;
    logic        pulse_q, pulse_d;
    logic        pv_q, pv_d;
    logic        err_q, err_d;
    logic        multi;

    assign raw = {bus.reflectR, bus.reflectM, bus.reflectF};

    // Input path: 2-flop synchroniser, debounce state and previous filtered level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            prev_q  <= '0;
            for (int i = 0; i < 3; i++) deb_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            for (int i = 0; i < 3; i++) deb_q[i] <= deb_d[i];
        end
    end

    // Debounce: accept the synced level once it has differed for DEBOUNCE_CYCLES cycles
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 3; i++) begin
            deb_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (deb_q[i] == CntMax) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    deb_d[i] = deb_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise     = filt_q & ~prev_q;
    assign multi    = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
    // Saturating increment doubles as the period of an edge arriving now
    assign pcnt_inc = (pcnt_q == '1) ? pcnt_q : pcnt_q + 32'd1;

    // Decoded state: sequence checker, count, position and period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            position_q <= '0;
            period_q   <= '0;
            pcnt_q     <= '0;
            pulse_q    <= 1'b0;
            pv_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            position_q <= position_d;
            period_q   <= period_d;
            pcnt_q     <= pcnt_d;
            pulse_q    <= pulse_d;
            pv_q       <= pv_d;
            err_q      <= err_d;
        end
    end

    // Next-state: sequence FSM plus front-edge bookkeeping; clear wins over any edge
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        position_d = position_q;
        period_d   = period_q;
        pcnt_d     = pcnt_inc;
        pulse_d    = 1'b0;
        pv_d       = 1'b0;
        err_d      = err_q;

        if (bus.clear) begin
            state_d    = StIdle;
            count_d    = '0;
            position_d = '0;
            period_d   = '0;
            pcnt_d     = '0;
            err_d      = 1'b0;
        end else begin
            if (multi) begin
                err_d   = 1'b1;
                state_d = rise[0] ? StSeenF : StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (rise[0]) begin
                            state_d = StSeenF;
                        end else if (rise[1] || rise[2]) begin
                            err_d = 1'b1;
                        end
                    end
                    StSeenF: begin
                        if (rise[1]) begin
                            state_d = StSeenM;
                        end else if (rise[0]) begin
                            err_d = 1'b1;
                        end else if (rise[2]) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end
                    StSeenM: begin
                        if (rise[2]) begin
                            state_d = StIdle;
                        end else if (rise[0]) begin
                            err_d   = 1'b1;
                            state_d = StSeenF;
                        end else if (rise[1]) begin
                            err_d = 1'b1;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end

            if (rise[0]) begin
                pulse_d = 1'b1;
                pcnt_d  = '0;
                // A zero count means this is the first front edge since reset/clear
                if (count_q != '0) begin
                    period_d = pcnt_inc;
                    pv_d     = 1'b1;
                end
                if (count_q != '1) begin
                    count_d    = count_q + 16'd1;
                    position_d = (count_q == '0) ? FIRST_OFFSET : position_q + STRIPE_PITCH;
                end
            end
        end
    end

    assign bus.stripe_count = count_q;
    assign bus.position     = position_q;
    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;
    assign bus.stripe_pulse = pulse_q;
    assign bus.seq_error    = err_q;
endmodule

// File: tb/tb_stripe_decoder.sv
// Bench for stripe_decoder: directed scenarios then random sensor traffic, all
// checked every cycle against a behavioural model, plus literal spot checks.
module tb_stripe_decoder;
    localparam int          D       = 4;
    localparam logic [63:0] PITCH   = 64'd30480000000;
    localparam logic [63:0] OFFSET  = 64'd15240000000;
    localparam logic [63:0] PRE_POS = 64'd1000000000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] pin = 3'b000;   // {R, M, F}
    logic       clr = 1'b0;
    logic       preload = 1'b0;
    int         lit_id = 0;
    int         hold [3];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stripe_decoder_if bus ();
    assign bus.reflectF = pin[0];
    assign bus.reflectM = pin[1];
    assign bus.reflectR = pin[2];
    assign bus.clear    = clr;

    stripe_decoder #(
        .STRIPE_PITCH   (PITCH),
        .FIRST_OFFSET   (OFFSET),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- behavioural model ----------------
    logic [2:0]  pinq [$];      // pin level seen at each clock edge
    logic [2:0]  acc;           // accepted (debounced) level per sensor
    logic [2:0]  pend;          // accepted rises, reported on the following edge
    int          st;            // 0 expects F, 1 expects M, 2 expects R
    int          e_cnt;
    logic [63:0] e_pos;
    logic [31:0] e_per;
    logic        e_pv, e_pulse, e_err, have_f;
    longint      cyc = 0;
    longint      last_f = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic mreset();
        pinq.delete();
        for (int i = 0; i < D + 2; i++) pinq.push_back(3'b000);
        acc = '0; pend = '0; st = 0;
        e_cnt = 0; e_pos = '0; e_per = '0;
        e_pv = 0; e_pulse = 0; e_err = 0; have_f = 0;
        last_f = cyc;
    endtask

    task automatic mstep();
        int         sz;
        int         which;
        logic [2:0] r;
        bit         all_diff;
        longint     gap;
        cyc++;
        sz = pinq.size();
        r  = pend;
        // Level accepted once the last D synced samples (pins two edges old) all differ
        for (int s = 0; s < 3; s++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= D; j++) if (pinq[sz - 1 - j][s] == acc[s]) all_diff = 1'b0;
            pend[s] = 1'b0;
            if (all_diff) begin
                acc[s]  = ~acc[s];
                pend[s] = acc[s];
            end
        end
        pinq.push_back(pin);
        if (pinq.size() > D + 2) void'(pinq.pop_front());

        e_pulse = 0;
        e_pv    = 0;
        if (clr) begin
            st = 0; e_cnt = 0; e_pos = '0; e_per = '0; e_err = 0; have_f = 0;
            last_f = cyc;
        end else begin
            if ($countones(r) >= 2) begin
                e_err = 1;
                st    = r[0] ? 1 : 0;
            end else if ($countones(r) == 1) begin
                which = r[0] ? 0 : (r[1] ? 1 : 2);
                if (which == st) begin
                    st = (st + 1) % 3;
                end else begin
                    // Misplaced F starts a new stripe; a repeated M holds; else abandon
                    e_err = 1;
                    if (which == 0) st = 1;
                    else if (st == 2 && which == 1) st = 2;
                    else st = 0;
                end
            end
            if (r[0]) begin
                e_pulse = 1;
                if (have_f) begin
                    gap   = cyc - last_f;
                    e_per = (gap > 64'hFFFFFFFF) ? 32'hFFFFFFFF : 32'(gap);
                    e_pv  = 1;
                end
                have_f = 1;
                last_f = cyc;
                if (e_cnt < 65535) begin
                    e_pos = (e_cnt == 0) ? OFFSET : e_pos + PITCH;
                    e_cnt++;
                end
            end
        end
        // Preloaded count stands in for prior edges
        if (preload) begin
            e_cnt  = 16'hFFFD;
            e_pos  = PRE_POS;
            have_f = 1;
        end
    endtask

    task automatic lit_check(input int id);
        case (id)
            1: begin
                cmp("t1_pulse", 64'(bus.stripe_pulse), 1);
                cmp("t1_count", 64'(bus.stripe_count), 1);
                cmp("t1_position", bus.position, 64'd15240000000);
                cmp("t1_period_valid", 64'(bus.period_valid), 0);
            end
            2: begin
                cmp("t2_count", 64'(bus.stripe_count), 2);
                cmp("t2_position", bus.position, 64'd45720000000);
                cmp("t2_period", 64'(bus.period), 1000);
                cmp("t2_period_valid", 64'(bus.period_valid), 1);
                cmp("t2_seq_error", 64'(bus.seq_error), 0);
                cmp("t2_model_period", 64'(e_per), 1000);
            end
            3: begin
                cmp("t3_glitch_count", 64'(bus.stripe_count), 2);
                cmp("t3_glitch_pulse", 64'(bus.stripe_pulse), 0);
            end
            4: begin
                cmp("t4_seq_error", 64'(bus.seq_error), 1);
                cmp("t4_count", 64'(bus.stripe_count), 3);
            end
            5: begin
                cmp("t4_next_f_count", 64'(bus.stripe_count), 4);
                cmp("t4_sticky_error", 64'(bus.seq_error), 1);
            end
            6: begin
                cmp("t4_clear_count", 64'(bus.stripe_count), 0);
                cmp("t4_clear_position", bus.position, 0);
                cmp("t4_clear_period", 64'(bus.period), 0);
                cmp("t4_clear_error", 64'(bus.seq_error), 0);
            end
            7: begin
                cmp("t5_multi_error", 64'(bus.seq_error), 1);
                cmp("t5_multi_count", 64'(bus.stripe_count), 1);
                cmp("t5_multi_position", bus.position, 64'd15240000000);
                cmp("t5_model_count", 64'(e_cnt), 1);
            end
            8: begin
                cmp("t5_drop_count", 64'(bus.stripe_count), 0);
                cmp("t5_drop_pulse", 64'(bus.stripe_pulse), 0);
                cmp("t5_drop_error", 64'(bus.seq_error), 0);
            end
            9: begin
                cmp("t6_sat_pulse", 64'(bus.stripe_pulse), 1);
                cmp("t6_sat_count", 64'(bus.stripe_count), 64'hFFFF);
                cmp("t6_sat_position", bus.position, PRE_POS + 2 * PITCH);
            end
            10: begin
                cmp("t6_rst_count", 64'(bus.stripe_count), 0);
                cmp("t6_rst_position", bus.position, 0);
                cmp("t6_rst_period", 64'(bus.period), 0);
                cmp("t6_rst_error", 64'(bus.seq_error), 0);
            end
            11: begin
                cmp("t6_post_rst_pulse", 64'(bus.stripe_pulse), 1);
                cmp("t6_post_rst_count", 64'(bus.stripe_count), 1);
                cmp("t6_post_rst_position", bus.position, 64'd15240000000);
            end
            default: ;
        endcase
    endtask

    // Model advance and full output comparison on every clock edge and reset
    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) mreset();
            else mstep();
            #1;
            cmp("stripe_count", 64'(bus.stripe_count), 64'(e_cnt));
            cmp("position", bus.position, e_pos);
            cmp("period", 64'(bus.period), 64'(e_per));
            cmp("period_valid", 64'(bus.period_valid), 64'(e_pv));
            cmp("stripe_pulse", 64'(bus.stripe_pulse), 64'(e_pulse));
            cmp("seq_error", 64'(bus.seq_error), 64'(e_err));
            if (lit_id != 0) lit_check(lit_id);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Request a literal check at the next clock edge
    task automatic lit(input int id);
        lit_id = id;
        @(negedge clk);
        lit_id = 0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(5);

        // Clean F, M, R pulses then a second F 1000 cycles after the first
        pin[0] = 1'b1; wait_n(6); lit(1); wait_n(13); pin[0] = 1'b0;
        wait_n(30); pin[1] = 1'b1; wait_n(20); pin[1] = 1'b0;
        wait_n(30); pin[2] = 1'b1; wait_n(20); pin[2] = 1'b0;
        wait_n(880);
        pin[0] = 1'b1; wait_n(6); lit(2); wait_n(13); pin[0] = 1'b0;
        wait_n(30);

        // Short glitch on F must be rejected
        pin[0] = 1'b1; wait_n(3); pin[0] = 1'b0; wait_n(20); lit(3);

        // F then R with M missing, then a further F, then clear
        pin[0] = 1'b1; wait_n(10); pin[0] = 1'b0; wait_n(20);
        pin[2] = 1'b1; wait_n(10); pin[2] = 1'b0; wait_n(20); lit(4);
        pin[0] = 1'b1; wait_n(10); pin[0] = 1'b0; wait_n(20); lit(5);
        clr = 1'b1; @(negedge clk); clr = 1'b0; lit(6);

        // F and M together, then clear coinciding with an F edge
        pin[1:0] = 2'b11; wait_n(10); pin[1:0] = 2'b00; wait_n(20); lit(7);
        clr = 1'b1; @(negedge clk); clr = 1'b0; wait_n(5);
        pin[0] = 1'b1; wait_n(6); clr = 1'b1; lit(8); clr = 1'b0;
        wait_n(10); pin[0] = 1'b0; wait_n(20); lit(8);

        // Preload near saturation, then three more front edges
        force dut.count_q = 16'hFFFD;
        force dut.position_q = PRE_POS;
        preload = 1'b1;
        @(negedge clk);
        release dut.count_q;
        release dut.position_q;
        preload = 1'b0;
        wait_n(5);
        for (int i = 0; i < 3; i++) begin
            pin[0] = 1'b1; wait_n(6);
            if (i == 2) lit(9);
            else wait_n(1);
            wait_n(9); pin[0] = 1'b0; wait_n(20);
        end

        // Asynchronous reset mid-pulse; a sensor still high afterwards must re-debounce
        pin[0] = 1'b1; wait_n(3);
        @(posedge clk); #2 rst_n = 1'b0;
        lit(10);
        wait_n(3); rst_n = 1'b1;
        wait_n(6); lit(11);
        wait_n(10); pin[0] = 1'b0; wait_n(20);

        // Random sensor traffic with occasional clears
        for (int s = 0; s < 3; s++) hold[s] = $urandom_range(1, 14);
        repeat (4000) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                if (hold[s] == 0) begin
                    pin[s]  = ~pin[s];
                    hold[s] = $urandom_range(1, 14);
                end else begin
                    hold[s]--;
                end
            end
            clr = ($urandom_range(0, 199) == 0);
        end
        clr = 1'b0;
        wait_n(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
